// File: rtl/pixel_cmd_decoder.sv
// Pixel command decoder.
//
// Turns the byte stream of an SPI slave into pixel RAM writes, a pixel-count
// configuration register and frame refresh requests. Each chip-select frame
// starts with a command byte. The rising edge of chip select ends the frame
// (cs_end).
//
// Handshake: byte_vld_i is a single-cycle strobe that qualifies byte_data_i.
// There is no ready signal. Every strobe is consumed in the cycle it arrives,
// including strobes on back-to-back cycles. All effects of a byte (RAM write,
// frame_go_o) appear on registered outputs one cycle after the strobe.
//
// The FSM state is exported on dbg_state_o. Encoding:
// 0 = CMD, 1 = PIX, 2 = CFG, 3 = DROP.
module pixel_cmd_decoder #(
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              spi_cs_n_i,
  input  logic              byte_vld_i,
  input  logic [7:0]        byte_data_i,
  output logic              ram_wr_en_o,
  output logic [ADDR_W-1:0] ram_wr_addr_o,
  output logic [23:0]       ram_wr_data_o,
  output logic [ADDR_W-1:0] pixel_num_o,
  output logic              frame_go_o,
  output logic              ovf_o,
  output logic [1:0]        dbg_state_o
);

  localparam logic [1:0] ST_CMD  = 2'd0;
  localparam logic [1:0] ST_PIX  = 2'd1;
  localparam logic [1:0] ST_CFG  = 2'd2;
  localparam logic [1:0] ST_DROP = 2'd3;

  localparam logic [7:0] CMD_PIXELS = 8'h2A;
  localparam logic [7:0] CMD_CONFIG = 8'h2B;
  localparam logic [7:0] CMD_FRAME  = 8'h2C;

  localparam logic [ADDR_W-1:0] PIX_NUM_RST = ADDR_W'(63);
  localparam logic [ADDR_W-1:0] ADDR_ONE    = ADDR_W'(1);

  // Chip-select synchronizer: two flops, plus one more flop that holds the
  // previous synchronized value for edge detection.
  logic cs_s1_q;
  logic cs_s2_q;
  logic cs_prev_q;
  logic cs_end;

  // Decoder state
  logic [1:0]        state_q,   state_d;
  logic [1:0]        bcnt_q,    bcnt_d;
  logic [7:0]        g_q,       g_d;
  logic [7:0]        r_q,       r_d;
  logic [ADDR_W-1:0] addr_q,    addr_d;
  // Set once address all-ones has been written. The address then holds and
  // does not wrap.
  logic              full_q,    full_d;

  // Registered outputs
  logic              wr_en_q,   wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [23:0]       wr_data_q, wr_data_d;
  logic [ADDR_W-1:0] pn_q,      pn_d;
  logic              fg_q,      fg_d;
  logic              ovf_q,     ovf_d;

  // The configuration byte is truncated to fit a narrow address. It is
  // zero-extended when the address is wider than 8 bits.
  logic [ADDR_W-1:0] cfg_val;
  generate
    if (ADDR_W <= 8) begin : g_cfg_narrow
      assign cfg_val = byte_data_i[ADDR_W-1:0];
    end else begin : g_cfg_wide
      assign cfg_val = {{(ADDR_W-8){1'b0}}, byte_data_i};
    end
  endgenerate

  // Bring spi_cs_n_i into the clock domain. Idle-high reset values prevent a
  // false cs_end after reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cs_s1_q   <= 1'b1;
      cs_s2_q   <= 1'b1;
      cs_prev_q <= 1'b1;
    end else begin
      cs_s1_q   <= spi_cs_n_i;
      cs_s2_q   <= cs_s1_q;
      cs_prev_q <= cs_s2_q;
    end
  end

  assign cs_end = cs_s2_q & ~cs_prev_q;

  // Next-state logic. The byte is decoded in the current state first. cs_end
  // then overrides the state, so a byte that coincides with the end of the
  // frame still has its full effect.
  always_comb begin
    state_d   = state_q;
    bcnt_d    = bcnt_q;
    g_d       = g_q;
    r_d       = r_q;
    addr_d    = addr_q;
    full_d    = full_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    pn_d      = pn_q;
    fg_d      = 1'b0;
    ovf_d     = ovf_q;

    if (byte_vld_i) begin
      case (state_q)
        ST_CMD: begin
          case (byte_data_i)
            CMD_PIXELS: begin
              state_d = ST_PIX;
              addr_d  = '0;
              bcnt_d  = 2'd0;
              full_d  = 1'b0;
              ovf_d   = 1'b0;
            end
            CMD_CONFIG: begin
              state_d = ST_CFG;
            end
            CMD_FRAME: begin
              state_d = ST_DROP;
              fg_d    = 1'b1;
            end
            default: begin
              state_d = ST_DROP;
            end
          endcase
        end

        ST_PIX: begin
          case (bcnt_q)
            2'd0: begin
              g_d    = byte_data_i;
              bcnt_d = 2'd1;
            end
            2'd1: begin
              r_d    = byte_data_i;
              bcnt_d = 2'd2;
            end
            default: begin
              // Third byte (blue). The triplet is complete.
              bcnt_d = 2'd0;
              if (full_q) begin
                ovf_d = 1'b1;
              end else begin
                wr_en_d   = 1'b1;
                wr_addr_d = addr_q;
                wr_data_d = {g_q, r_q, byte_data_i};
                if (addr_q == '1) begin
                  full_d = 1'b1;
                end else begin
                  addr_d = addr_q + ADDR_ONE;
                end
              end
            end
          endcase
        end

        ST_CFG: begin
          pn_d    = cfg_val;
          state_d = ST_DROP;
        end

        default: begin
          // ST_DROP: ignore everything until the frame ends.
        end
      endcase
    end

    // End of frame. Return to command decode and discard any partial triplet.
    if (cs_end) begin
      state_d = ST_CMD;
      bcnt_d  = 2'd0;
    end
  end

  // State and output registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_CMD;
      bcnt_q    <= 2'd0;
      g_q       <= 8'h00;
      r_q       <= 8'h00;
      addr_q    <= '0;
      full_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 24'h000000;
      pn_q      <= PIX_NUM_RST;
      fg_q      <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bcnt_q    <= bcnt_d;
      g_q       <= g_d;
      r_q       <= r_d;
      addr_q    <= addr_d;
      full_q    <= full_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      pn_q      <= pn_d;
      fg_q      <= fg_d;
      ovf_q     <= ovf_d;
    end
  end

  assign ram_wr_en_o   = wr_en_q;
  assign ram_wr_addr_o = wr_addr_q;
  assign ram_wr_data_o = wr_data_q;
  assign pixel_num_o   = pn_q;
  assign frame_go_o    = fg_q;
  assign ovf_o         = ovf_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_pixel_cmd_decoder.sv
// Testbench for pixel_cmd_decoder.
// A reference model consumes each cycle's inputs. It predicts the outputs that
// must be visible after that cycle's rising edge. The outputs are compared on
// the following falling edge.
module tb_pixel_cmd_decoder;

  localparam int ADDR_W   = 8;
  localparam int MAX_ADDR = (1 << ADDR_W) - 1;
  localparam int M_CMD = 0, M_PIX = 1, M_CFG = 2, M_DROP = 3;

  logic              clk;
  logic              rst_n;
  logic              spi_cs_n;
  logic              byte_vld;
  logic [7:0]        byte_data;
  logic              ram_wr_en;
  logic [ADDR_W-1:0] ram_wr_addr;
  logic [23:0]       ram_wr_data;
  logic [ADDR_W-1:0] pixel_num;
  logic              frame_go;
  logic              ovf;
  logic [1:0]        dbg_state;

  pixel_cmd_decoder #(.ADDR_W(ADDR_W)) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .spi_cs_n_i    (spi_cs_n),
    .byte_vld_i    (byte_vld),
    .byte_data_i   (byte_data),
    .ram_wr_en_o   (ram_wr_en),
    .ram_wr_addr_o (ram_wr_addr),
    .ram_wr_data_o (ram_wr_data),
    .pixel_num_o   (pixel_num),
    .frame_go_o    (frame_go),
    .ovf_o         (ovf),
    .dbg_state_o   (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model
  int                m_mode;
  logic [7:0]        m_pix[$];   // bytes of the triplet being collected
  int                m_next;     // next pixel index; may exceed MAX_ADDR
  bit                m_ovf;
  logic [ADDR_W-1:0] m_pn;
  bit                e_wr;
  bit                e_fg;
  logic [ADDR_W-1:0] e_addr;
  logic [23:0]       e_data;
  bit                h1, h2, h3; // chip select seen 1, 2 and 3 cycles ago
  logic [ADDR_W+23:0] exp_q[$];  // scoreboard of expected {addr,data} writes
  logic [7:0]        fr_q[$];    // bytes of the frame to send

  task automatic model_reset();
    m_mode = M_CMD;
    m_pix.delete();
    m_next = 0;
    m_ovf  = 1'b0;
    m_pn   = ADDR_W'(63);
    e_wr   = 1'b0;
    e_fg   = 1'b0;
    e_addr = '0;
    e_data = 24'h0;
    h1 = 1'b1; h2 = 1'b1; h3 = 1'b1;
    exp_q.delete();
  endtask

  task automatic model_step(input bit vld, input logic [7:0] d, input bit cs);
    bit cs_end;
    cs_end = h2 && !h3;
    e_wr = 1'b0;
    e_fg = 1'b0;
    if (vld) begin
      case (m_mode)
        M_CMD: begin
          if (d == 8'h2A) begin
            m_mode = M_PIX; m_pix.delete(); m_next = 0; m_ovf = 1'b0;
          end else if (d == 8'h2B) begin
            m_mode = M_CFG;
          end else if (d == 8'h2C) begin
            m_mode = M_DROP; e_fg = 1'b1;
          end else begin
            m_mode = M_DROP;
          end
        end
        M_PIX: begin
          m_pix.push_back(d);
          if (m_pix.size() == 3) begin
            if (m_next <= MAX_ADDR) begin
              e_wr   = 1'b1;
              e_addr = ADDR_W'(m_next);
              e_data = {m_pix[0], m_pix[1], m_pix[2]};
              exp_q.push_back({e_addr, e_data});
              m_next++;
            end else begin
              m_ovf = 1'b1;
            end
            m_pix.delete();
          end
        end
        M_CFG: begin
          m_pn   = ADDR_W'(d);
          m_mode = M_DROP;
        end
        default: ;
      endcase
    end
    if (cs_end) begin
      m_mode = M_CMD;
      m_pix.delete();
    end
    h3 = h2; h2 = h1; h1 = cs;
  endtask

  task automatic check_outputs();
    logic [ADDR_W+23:0] w;
    chk("wr_en", ram_wr_en, e_wr);
    if (ram_wr_en === 1'b1) begin
      if (exp_q.size() > 0) begin
        w = exp_q.pop_front();
        chk("wr_sb_addr", ram_wr_addr, w[ADDR_W+23:24]);
        chk("wr_sb_data", ram_wr_data, w[23:0]);
      end else begin
        chk("wr_unexpected", ram_wr_en, 1'b0);
      end
    end
    chk("wr_addr", ram_wr_addr, e_addr);
    chk("wr_data", ram_wr_data, e_data);
    chk("frame_go", frame_go, e_fg);
    chk("ovf", ovf, m_ovf);
    chk("pixel_num", pixel_num, m_pn);
  endtask

  // Driver tasks
  task automatic cycle(input bit vld, input logic [7:0] d, input bit cs);
    byte_vld  = vld;
    byte_data = vld ? d : 8'($urandom);
    spi_cs_n  = cs;
    @(posedge clk);
    model_step(vld, d, cs);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic send_frame();
    foreach (fr_q[i]) cycle(1'b1, fr_q[i], 1'b0);
    repeat (5) cycle(1'b0, 8'h00, 1'b1);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_wr_en"}, ram_wr_en, 1'b0);
    chk({tag, "_wr_addr"}, ram_wr_addr, 0);
    chk({tag, "_wr_data"}, ram_wr_data, 0);
    chk({tag, "_frame_go"}, frame_go, 1'b0);
    chk({tag, "_ovf"}, ovf, 1'b0);
    chk({tag, "_pixel_num"}, pixel_num, 63);
  endtask

  // Asynchronous reset pulse between clock edges. Chip select is left as is.
  task automatic do_reset();
    byte_vld = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_values("rst_mid");
    model_reset();
    #1;
    rst_n = 1'b1;
  endtask

  // Stimulus
  initial begin
    int n, sent;
    rst_n = 1'b1; spi_cs_n = 1'b1; byte_vld = 1'b0; byte_data = 8'h00;
    #2 rst_n = 1'b0;
    #1 check_reset_values("rst_init");
    repeat (2) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    repeat (3) cycle(1'b0, 8'h00, 1'b1);

    // Two pixels
    fr_q = '{8'h2A, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    send_frame();
    chk("s31_addr", ram_wr_addr, 1);
    chk("s31_data", ram_wr_data, 24'h445566);

    // Configuration
    fr_q = '{8'h2B, 8'h0F};
    send_frame();
    chk("s32_pixel_num", pixel_num, 8'h0F);

    // Frame request followed by a normal pixel frame
    fr_q = '{8'h2C};
    send_frame();
    fr_q = '{8'h2A, 8'h01, 8'h02, 8'h03};
    send_frame();
    chk("s33_addr", ram_wr_addr, 0);
    chk("s33_data", ram_wr_data, 24'h010203);

    // 257 triplets: the last one overflows
    fr_q.delete();
    fr_q.push_back(8'h2A);
    for (int i = 0; i < 257 * 3; i++) fr_q.push_back(8'($urandom));
    send_frame();
    chk("s34_ovf_set", ovf, 1'b1);
    chk("s34_addr_last", ram_wr_addr, MAX_ADDR);
    fr_q = '{8'h2A};
    send_frame();
    chk("s34_ovf_clear", ovf, 1'b0);

    // A partial triplet is discarded at the end of the frame
    fr_q = '{8'h2A, 8'hAA, 8'hBB};
    send_frame();
    fr_q = '{8'h2A, 8'h01, 8'h02, 8'h03};
    send_frame();
    chk("s35_addr", ram_wr_addr, 0);
    chk("s35_data", ram_wr_data, 24'h010203);

    // A byte that coincides with cs_end is processed; then a command follows
    cycle(1'b1, 8'h2A, 1'b0);
    cycle(1'b1, 8'hA1, 1'b0);
    cycle(1'b1, 8'hB2, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b1, 8'hC3, 1'b1);
    chk("coin_wr_data", ram_wr_data, 24'hA1B2C3);
    cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b1, 8'h2C, 1'b0);
    chk("coin_frame_go", frame_go, 1'b1);
    repeat (5) cycle(1'b0, 8'h00, 1'b1);

    // Reset in the middle of a frame; chip select stays low afterwards
    cycle(1'b1, 8'h2A, 1'b0);
    cycle(1'b1, 8'h11, 1'b0);
    do_reset();
    cycle(1'b1, 8'h2B, 1'b0);
    cycle(1'b1, 8'h05, 1'b0);
    chk("s36_pixel_num", pixel_num, 5);
    repeat (5) cycle(1'b0, 8'h00, 1'b1);

    // Random frames with gaps and bytes arriving around the end of the frame
    for (int f = 0; f < 60; f++) begin
      case ($urandom_range(0, 3))
        0: cycle(1'b1, 8'h2A, 1'b0);
        1: cycle(1'b1, 8'h2B, 1'b0);
        2: cycle(1'b1, 8'h2C, 1'b0);
        default: cycle(1'b1, 8'($urandom), 1'b0);
      endcase
      n = $urandom_range(0, 14);
      sent = 0;
      while (sent < n) begin
        if ($urandom_range(0, 2) != 0) begin
          cycle(1'b1, 8'($urandom), 1'b0);
          sent++;
        end else begin
          cycle(1'b0, 8'h00, 1'b0);
        end
      end
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) cycle($urandom_range(0, 1) == 1, 8'($urandom), 1'b1);
    end
    repeat (5) cycle(1'b0, 8'h00, 1'b1);

    chk("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
